// File: rtl/ad747x_pkg.sv
// rtl/ad747x_pkg.sv - shared types and elaboration helpers for the AD747x multi-channel reader
// Holds the FSM state type, counter sizing and the parameter legality check.
package ad747x_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_QUIET
  } state_e;

  // Width of a counter that must hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int clk_divisor, input int data_width,
                                   input int lead_bits, input int frame_bits,
                                   input int num_ch, input int quiet_cycles);
    return (clk_divisor >= 4) && (clk_divisor % 2 == 0) &&
           (data_width >= 1) && (lead_bits >= 0) &&
           (frame_bits >= lead_bits + data_width) &&
           (num_ch >= 1) && (num_ch <= 8) &&
           (quiet_cycles >= 5);
  endfunction

endpackage

// File: rtl/ad747x_multi_rx_if.sv
// rtl/ad747x_multi_rx_if.sv - pin and result-handshake bundle of the AD747x multi-channel reader
// The master modport is the reader itself; slave is the environment around it.
interface ad747x_multi_rx_if #(
  parameter int NUM_CH     = 1,
  parameter int DATA_WIDTH = 12
);

  logic                         Enable;
  logic                         Trigger;
  logic [NUM_CH-1:0]            Miso;
  logic                         Ss;
  logic                         Sck;
  logic [NUM_CH*DATA_WIDTH-1:0] Data;
  logic                         Valid;
  logic                         Ready;
  logic                         Busy;
  logic                         Overrun;

  modport master (
    input  Enable, Trigger, Miso, Ready,
    output Ss, Sck, Data, Valid, Busy, Overrun
  );

  modport slave (
    output Enable, Trigger, Miso, Ready,
    input  Ss, Sck, Data, Valid, Busy, Overrun
  );

endinterface

// File: rtl/ad747x_chan_shift.sv
// rtl/ad747x_chan_shift.sv - per-ADC result shift register
// Shifts in the registered Miso bit MSB first, only while the bit index is inside the data window.
module ad747x_chan_shift #(
  parameter int DATA_WIDTH = 12,
  parameter int LEAD_BITS  = 4,
  parameter int BW         = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  sample_en_i,
  input  logic [BW-1:0]         bit_idx_i,
  input  logic                  miso_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [BW-1:0] FIRST_IDX = BW'(LEAD_BITS);
  localparam logic [BW-1:0] LAST_IDX  = BW'(LEAD_BITS + DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH:0]   sr_ext;
  logic                  in_window;

  always_comb begin
    in_window = (bit_idx_i >= FIRST_IDX) && (bit_idx_i <= LAST_IDX);
    sr_ext    = {sr_q, miso_i};
    sr_d      = sr_q;
    if (sample_en_i && in_window) begin
      sr_d = sr_ext[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_o = sr_q;

endmodule

// File: rtl/ad747x_multi_rx.sv
// rtl/ad747x_multi_rx.sv - shared-CS/SCK reader for NUM_CH AD747x serial ADCs
// Owns the frame FSM, SCK divider, bit counter and the Valid/Ready result register.
module ad747x_multi_rx
  import ad747x_pkg::*;
#(
  parameter int CLK_DIVISOR  = 6,
  parameter int DATA_WIDTH   = 12,
  parameter int LEAD_BITS    = 4,
  parameter int FRAME_BITS   = 16,
  parameter int NUM_CH       = 1,
  parameter int QUIET_CYCLES = 6
) (
  input  logic              Clk,
  input  logic              Rst_n,
  ad747x_multi_rx_if.master bus
);

  localparam int HALF    = CLK_DIVISOR / 2;
  localparam int CNT_MAX = (CLK_DIVISOR > QUIET_CYCLES) ? CLK_DIVISOR : QUIET_CYCLES;
  localparam int CW      = cnt_width(CNT_MAX);
  localparam int BW      = cnt_width(FRAME_BITS);

  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIVISOR - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  if (!params_ok(CLK_DIVISOR, DATA_WIDTH, LEAD_BITS, FRAME_BITS, NUM_CH, QUIET_CYCLES))
  begin : g_param_err
    $fatal(1, "ad747x_multi_rx: illegal parameter combination");
  end

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [BW-1:0]                bit_q, bit_d;
  logic                         ss_q, ss_d;
  logic                         sck_q, sck_d;
  logic                         pending_q, pending_d;
  logic                         valid_q, valid_d;
  logic                         overrun_q;
  logic [NUM_CH-1:0]            miso_q;
  logic [NUM_CH*DATA_WIDTH-1:0] data_q;
  logic [NUM_CH*DATA_WIDTH-1:0] shift_data;
  logic                         sample_en;
  logic                         frame_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ss_d       = ss_q;
    sck_d      = sck_q;
    pending_d  = pending_q;
    sample_en  = 1'b0;
    frame_done = 1'b0;

    // One-deep request memory; entering START below overrides this.
    if (bus.Trigger && !bus.Enable && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.Enable || bus.Trigger || pending_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          ss_d      = 1'b0;
          sck_d     = 1'b1;
          pending_d = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        // Sampling on the 0->1 SCK edge sees Miso settled for a full low half.
        if (cnt_q == HALF_LAST) begin
          sck_d     = 1'b1;
          sample_en = 1'b1;
        end
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d    = S_QUIET;
            ss_d       = 1'b1;
            sck_d      = 1'b1;
            frame_done = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            sck_d = 1'b0;
          end
        end
      end
      S_QUIET: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == QUIET_LAST) begin
          cnt_d = '0;
          if (bus.Enable || pending_q) begin
            state_d   = S_START;
            ss_d      = 1'b0;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept-then-load when a result lands on the same edge as Ready.
    valid_d = frame_done | (valid_q & ~bus.Ready);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      ss_q      <= 1'b1;
      sck_q     <= 1'b1;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      miso_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ss_q      <= ss_d;
      sck_q     <= sck_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      overrun_q <= frame_done & valid_q & ~bus.Ready;
      miso_q    <= bus.Miso;
      if (frame_done) begin
        data_q <= shift_data;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ad747x_chan_shift #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAD_BITS  (LEAD_BITS),
      .BW         (BW)
    ) u_shift (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .sample_en_i (sample_en),
      .bit_idx_i   (bit_q),
      .miso_i      (miso_q[c]),
      .data_o      (shift_data[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.Ss      = ss_q;
  assign bus.Sck     = sck_q;
  assign bus.Data    = data_q;
  assign bus.Valid   = valid_q;
  assign bus.Busy    = (state_q != S_IDLE);
  assign bus.Overrun = overrun_q;

endmodule

// File: tb/tb_ad747x_multi_rx.sv
// tb/tb_ad747x_multi_rx.sv - bench for ad747x_multi_rx with behavioural ADC models
module tb_ad747x_multi_rx;

  typedef struct packed {
    logic [15:0] word;
    logic [11:0] exp;
  } stim_t;

  typedef struct {
    logic [3:0]  lead;
    logic [11:0] data;
    logic [11:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;

  ad747x_multi_rx_if #(.NUM_CH(1), .DATA_WIDTH(12)) if_a ();
  ad747x_multi_rx_if #(.NUM_CH(4), .DATA_WIDTH(12)) if_b ();
  ad747x_multi_rx_if #(.NUM_CH(1), .DATA_WIDTH(8))  if_c ();

  ad747x_multi_rx u_a (.Clk(clk), .Rst_n(rst_n), .bus(if_a.master));
  ad747x_multi_rx #(.NUM_CH(4)) u_b (.Clk(clk), .Rst_n(rst_n), .bus(if_b.master));
  ad747x_multi_rx #(.DATA_WIDTH(8)) u_c (.Clk(clk), .Rst_n(rst_n), .bus(if_c.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- ADC model and scoreboard for instance A ----------------
  stim_t       stim_q_a[$];
  stim_t       cur_a;
  logic [11:0] sb_a[$];
  int idx_a, sck_cnt_a, last_sck_a, falls_a, rises_a, ovr_cnt_a, valid_rises_a;
  int fall_cyc_a, rise_cyc_a, last_low_a, last_period_a, last_gap_a;

  always @(negedge if_a.Ss) begin
    if (stim_q_a.size() > 0) cur_a = stim_q_a.pop_front();
    sb_a.push_back(cur_a.exp);
    idx_a         = 0;
    sck_cnt_a     = 0;
    if_a.Miso[0]  = cur_a.word[15];
    last_period_a = cyc - fall_cyc_a;
    last_gap_a    = cyc - rise_cyc_a;
    fall_cyc_a    = cyc;
    falls_a++;
  end

  always @(posedge if_a.Sck) begin
    if (!if_a.Ss) begin
      sck_cnt_a++;
      if (idx_a < 15) begin
        idx_a++;
        if_a.Miso[0] = cur_a.word[15-idx_a];
      end
    end
  end

  always @(posedge if_a.Ss) begin
    last_low_a = cyc - fall_cyc_a;
    last_sck_a = sck_cnt_a;
    rise_cyc_a = cyc;
    rises_a++;
  end

  always @(posedge if_a.Valid) valid_rises_a++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_a.Overrun) begin
        ovr_cnt_a++;
        if (sb_a.size() > 0) void'(sb_a.pop_front());
      end
      if (if_a.Valid && if_a.Ready) begin
        if (sb_a.size() == 0) check("a_sb_underflow", 64'd1, 64'd0);
        else check("a_sb_data", if_a.Data, sb_a.pop_front());
      end
    end
  end

  // ---------------- ADC models for instances B and C ----------------
  logic [15:0] word_b[4];
  logic [15:0] word_c;
  int idx_b, idx_c, falls_b;

  always @(negedge if_b.Ss) begin
    idx_b = 0;
    falls_b++;
    for (int c = 0; c < 4; c++) if_b.Miso[c] = word_b[c][15];
  end

  always @(posedge if_b.Sck) begin
    if (!if_b.Ss && idx_b < 15) begin
      idx_b++;
      for (int c = 0; c < 4; c++) if_b.Miso[c] = word_b[c][15-idx_b];
    end
  end

  always @(negedge if_c.Ss) begin
    idx_c = 0;
    if_c.Miso[0] = word_c[15];
  end

  always @(posedge if_c.Sck) begin
    if (!if_c.Ss && idx_c < 15) begin
      idx_c++;
      if_c.Miso[0] = word_c[15-idx_c];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t vecs[6];
  int   k, base, fbase, vbase, obase;
  logic seen_bad;

  initial begin
    vecs[0] = '{4'h0, 12'hA5C, 12'hA5C};
    vecs[1] = '{4'hF, 12'h000, 12'h000};
    vecs[2] = '{4'h0, 12'hFFF, 12'hFFF};
    vecs[3] = '{4'h5, 12'h123, 12'h123};
    vecs[4] = '{4'hA, 12'h800, 12'h800};
    vecs[5] = '{4'h3, 12'h7FF, 12'h7FF};

    n_tests = 0; n_fail = 0; cyc = 0;
    cur_a = '0;
    rst_n = 1'b0;
    if_a.Enable = 1'b0; if_a.Trigger = 1'b0; if_a.Ready = 1'b1; if_a.Miso = '0;
    if_b.Enable = 1'b0; if_b.Trigger = 1'b0; if_b.Ready = 1'b1; if_b.Miso = '0;
    if_c.Enable = 1'b0; if_c.Trigger = 1'b0; if_c.Ready = 1'b1; if_c.Miso = '0;
    word_b[0] = {4'h0, 12'h001};
    word_b[1] = {4'hF, 12'h7FF};
    word_b[2] = {4'h5, 12'h800};
    word_b[3] = {4'hA, 12'hFFF};
    word_c    = {4'h0, 8'h3C, 4'hB};

    repeat (3) @(negedge clk);
    check("rst_ss", if_a.Ss, 1);
    check("rst_sck", if_a.Sck, 1);
    check("rst_valid", if_a.Valid, 0);
    check("rst_data", if_a.Data, 0);
    check("rst_busy", if_a.Busy, 0);
    check("rst_overrun", if_a.Overrun, 0);
    tick(); rst_n = 1'b1;

    // Four channels, single trigger.
    fbase = falls_b;
    tick(); if_b.Trigger = 1'b1; tick(); if_b.Trigger = 1'b0;
    k = 0; while (!if_b.Valid && k < 300) begin @(negedge clk); k++; end
    check("b_valid_seen", if_b.Valid, 1);
    check("b_data", if_b.Data, {12'hFFF, 12'h800, 12'h7FF, 12'h001});
    k = 0; while (if_b.Busy && k < 50) begin @(negedge clk); k++; end
    repeat (150) @(negedge clk);
    check("b_busy_idle", if_b.Busy, 0);
    check("b_one_frame", falls_b - fbase, 1);

    // 8-bit part: lead and trailing bits must be dropped.
    for (int i = 0; i < 2; i++) begin
      if (i == 1) word_c = {4'hF, 8'hC3, 4'h5};
      tick(); if_c.Trigger = 1'b1; tick(); if_c.Trigger = 1'b0;
      k = 0; while (!if_c.Valid && k < 300) begin @(negedge clk); k++; end
      check("c_valid_seen", if_c.Valid, 1);
      check("c_data", if_c.Data, (i == 0) ? 64'h3C : 64'hC3);
      repeat (20) @(negedge clk);
    end

    // Table-driven single-shot conversions on A.
    vbase = valid_rises_a;
    for (int i = 0; i < 6; i++) begin
      stim_q_a.push_back(stim_t'{word: {vecs[i].lead, vecs[i].data}, exp: vecs[i].exp});
      base = rises_a;
      tick(); if_a.Trigger = 1'b1; tick(); if_a.Trigger = 1'b0;
      k = 0; while (rises_a == base && k < 300) begin @(negedge clk); k++; end
      check("a_vec_done", (rises_a != base), 1);
      repeat (15) @(negedge clk);
    end
    check("a_vec_valid_pulses", valid_rises_a - vbase, 6);
    check("a_vec_sb_drained", sb_a.size(), 0);

    // Free-running conversions.
    stim_q_a.push_back(stim_t'{word: {4'h0, 12'hA5C}, exp: 12'hA5C});
    base = rises_a; vbase = valid_rises_a;
    tick(); if_a.Enable = 1'b1;
    k = 0; while (rises_a < base + 3 && k < 500) begin @(negedge clk); k++; end
    check("fr_frames", rises_a - base, 3);
    check("fr_ss_low", last_low_a, 99);
    check("fr_period", last_period_a, 105);
    check("fr_sck_edges", last_sck_a, 16);
    check("fr_valid_pulses", valid_rises_a - vbase, 3);
    if_a.Enable = 1'b0;
    k = 0; while (if_a.Busy && k < 200) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);

    // Overrun with Ready held low for three frames.
    tick(); if_a.Ready = 1'b0;
    stim_q_a.push_back(stim_t'{word: {4'h0, 12'h111}, exp: 12'h111});
    stim_q_a.push_back(stim_t'{word: {4'h0, 12'h222}, exp: 12'h222});
    stim_q_a.push_back(stim_t'{word: {4'h0, 12'h333}, exp: 12'h333});
    base = rises_a; fbase = falls_a; obase = ovr_cnt_a;
    if_a.Enable = 1'b1;
    k = 0; while (rises_a < base + 3 && k < 500) begin @(negedge clk); k++; end
    if_a.Enable = 1'b0;
    k = 0; while (if_a.Busy && k < 50) begin @(negedge clk); k++; end
    check("ovr_pulses", ovr_cnt_a - obase, 2);
    check("ovr_data", if_a.Data, 12'h333);
    check("ovr_valid_held", if_a.Valid, 1);
    check("ovr_frames", falls_a - fbase, 3);
    tick(); if_a.Ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_clear", if_a.Valid, 0);
    check("ovr_sb_drained", sb_a.size(), 0);

    // Trigger storm: one pending frame, extras dropped.
    stim_q_a.push_back(stim_t'{word: {4'h0, 12'h5A3}, exp: 12'h5A3});
    stim_q_a.push_back(stim_t'{word: {4'hC, 12'h3A5}, exp: 12'h3A5});
    fbase = falls_a;
    tick(); if_a.Trigger = 1'b1; tick(); if_a.Trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (20) tick();
      if_a.Trigger = 1'b1; tick(); if_a.Trigger = 1'b0;
    end
    k = 0; while (falls_a < fbase + 2 && k < 300) begin @(negedge clk); k++; end
    check("trg_quiet_gap", last_gap_a, 6);
    k = 0; while (if_a.Busy && k < 300) begin @(negedge clk); k++; end
    repeat (150) @(negedge clk);
    check("trg_frames", falls_a - fbase, 2);
    check("trg_idle", if_a.Busy, 0);
    check("trg_sb_drained", sb_a.size(), 0);

    // Asynchronous reset in the middle of bit 7.
    stim_q_a.push_back(stim_t'{word: {4'h0, 12'h6B2}, exp: 12'h6B2});
    fbase = falls_a;
    tick(); if_a.Ready = 1'b0; if_a.Enable = 1'b1;
    k = 0; while (falls_a < fbase + 2 && k < 300) begin @(negedge clk); k++; end
    k = 0; while (sck_cnt_a < 8 && k < 100) begin @(negedge clk); k++; end
    check("rst_pre_valid", if_a.Valid, 1);
    check("rst_pre_ss", if_a.Ss, 0);
    #2; rst_n = 1'b0;
    #1;
    check("rst_async_ss", if_a.Ss, 1);
    check("rst_async_sck", if_a.Sck, 1);
    check("rst_async_valid", if_a.Valid, 0);
    check("rst_async_data", if_a.Data, 0);
    sb_a.delete();
    if_a.Enable = 1'b0; if_a.Ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_post_idle", if_a.Ss, 1);
    check("rst_post_novalid", if_a.Valid, 0);
    stim_q_a.push_back(stim_t'{word: {4'h0, 12'h19E}, exp: 12'h19E});
    tick(); if_a.Enable = 1'b1;
    seen_bad = 1'b0;
    k = 0;
    while (!if_a.Valid && k < 300) begin
      @(negedge clk); k++;
    end
    check("rst_new_valid", if_a.Valid, 1);
    check("rst_new_ss_high", if_a.Ss, 1);
    check("rst_new_full_frame", last_low_a, 99);
    if_a.Enable = 1'b0;
    k = 0; while (if_a.Busy && k < 200) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    check("rst_new_sb_drained", sb_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
